// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the branch resolution logic:
// funct3 branch encodings, resolve-FSM state type and the sequential PC step.
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } br_state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational RV32I branch condition from ALU flags of A-B (subtract).
// Unused funct3 codes (010/011) report illegal and resolve as not taken.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       negative,
  input  logic       overflow,
  input  logic       carry_out,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = negative ^ overflow;
      F3_BGE:  taken = !(negative ^ overflow);
      // carry_out is the unsigned borrow, so it means A < B
      F3_BLTU: taken = carry_out;
      F3_BGEU: taken = !carry_out;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: compares the evaluated condition with the prediction and,
// on a mispredict, issues a PC redirect plus a multi-cycle flush. Optional
// resolve/mispredict counters are built when BRANCH_STATS_EN is defined.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic        carry_out,
  output logic        ex_stall,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        illegal_branch,
  output logic [1:0]  dbg_state
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  br_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        ill_q, ill_d;

  logic        cond_taken;
  logic        cond_illegal;
  logic        resolve;
  logic        mispredict;
  logic [31:0] corr_pc;

  branch_cond u_cond (
    .funct3    (ex_funct3),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .carry_out (carry_out),
    .taken     (cond_taken),
    .illegal   (cond_illegal)
  );

  // EX is only sampled in IDLE; any other state stalls EX so the branch is re-presented.
  assign resolve    = ex_valid && ex_is_branch && (state_q == IDLE);
  assign mispredict = resolve && !cond_illegal && (cond_taken != ex_pred_taken);
  assign corr_pc    = cond_taken ? ex_target : (ex_pc + PC_INCR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ill_d   = resolve && cond_illegal;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          pc_d    = corr_pc;
          cnt_d   = FLUSH_LOAD;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q <= 4'd1) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= 32'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
    end
  end

  // Redirect handshake: redirect_valid rises in REDIRECT and redirect_pc is held
  // until the edge where redirect_valid && redirect_ready; ready alone does nothing.
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = pc_q;
  assign flush          = (state_q != IDLE);
  assign ex_stall       = (state_q != IDLE);
  assign illegal_branch = ill_q;
  assign dbg_state      = state_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      if (resolve) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (mispredict) begin
        mis_cnt_q <= mis_cnt_q + 32'd1;
      end
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases then random branches,
// checked by a scoreboard fed from an operand-level reference model.
module tb_branch_resolve;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_is_branch, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target;
  logic        zero, negative, overflow, carry_out;
  logic        ex_stall, redirect_valid, redirect_ready, flush, illegal_branch;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve #(.FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_funct3      (ex_funct3),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .zero           (zero),
    .negative       (negative),
    .overflow       (overflow),
    .carry_out      (carry_out),
    .ex_stall       (ex_stall),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .illegal_branch (illegal_branch),
    .dbg_state      (dbg_state)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 1;  // 0 random, 1 high, 2 low

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          ill_q[$];
  logic [31:0] mdl_branches = 0;
  logic [31:0] mdl_mispredicts = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       redirect_ready = ($urandom_range(0, 2) != 0);
      2:       redirect_ready = 1'b0;
      default: redirect_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: branch outcome from the operands themselves.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                output bit taken, output bit ill);
    taken = 1'b0;
    ill   = 1'b0;
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = !($signed(a) < $signed(b));
      3'b110:  taken = (a < b);
      3'b111:  taken = !(a < b);
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic set_operands(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d         = a - b;
    zero      = (d == 32'd0);
    negative  = d[31];
    overflow  = (a[31] != b[31]) && (d[31] != a[31]);
    carry_out = (a < b);
  endtask

  // driver: call at posedge+1; returns at posedge+1 after the branch was taken in
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit pred, input logic [31:0] pc, input logic [31:0] tgt);
    bit tk, il;
    int guard;
    guard = 0;
    while (ex_stall) begin
      ex_valid      = 1'b1;
      ex_is_branch  = 1'($urandom_range(0, 1));
      ex_funct3     = 3'($urandom);
      ex_pred_taken = 1'($urandom);
      ex_pc         = $urandom;
      ex_target     = $urandom;
      set_operands($urandom, $urandom);
      @(posedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL stall_timeout: ex_stall still 1 after %0d cycles, expected 0", guard);
        return;
      end
    end
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_funct3     = f3;
    ex_pred_taken = pred;
    ex_pc         = pc;
    ex_target     = tgt;
    set_operands(a, b);
    model(f3, a, b, tk, il);
    mdl_branches++;
    if (il) begin
      ill_q.push_back(cyc + 1);
    end else if (tk != pred) begin
      mdl_mispredicts++;
      exp_q.push_back(tk ? tgt : pc + 32'd4);
      lat_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
  endtask

  // monitor / scoreboard
  bit act = 1'b0;
  bit waiting = 1'b0;
  int flush_until = 0;

  always @(negedge clk) begin
    bit e_valid, e_flush, e_ill;
    if (reset) begin
      act     = 1'b0;
      waiting = 1'b0;
    end else begin
      if (lat_q.size() > 0 && lat_q[0] == cyc) begin
        void'(lat_q.pop_front());
        act     = 1'b1;
        waiting = 1'b1;
      end
      if (act && !waiting && cyc > flush_until) act = 1'b0;
      e_valid = act && waiting;
      e_flush = act;
      e_ill   = 1'b0;
      if (ill_q.size() > 0 && ill_q[0] == cyc) begin
        void'(ill_q.pop_front());
        e_ill = 1'b1;
      end
      check("redirect_valid", 32'(redirect_valid), 32'(e_valid));
      check("flush", 32'(flush), 32'(e_flush));
      check("ex_stall", 32'(ex_stall), 32'(e_flush));
      check("illegal_branch", 32'(illegal_branch), 32'(e_ill));
      if (e_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL redirect_pc: no expected entry, got 0x%08h", redirect_pc);
        end else begin
          check("redirect_pc", redirect_pc, exp_q[0]);
          if (redirect_ready) begin
            void'(exp_q.pop_front());
            waiting     = 1'b0;
            flush_until = cyc + FC - 1;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, pc;
    int guard;
    reset = 1'b1;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_funct3 = 3'd0; ex_pred_taken = 1'b0;
    ex_pc = 32'd0; ex_target = 32'd0;
    zero = 1'b0; negative = 1'b0; overflow = 1'b0; carry_out = 1'b0;
    redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_ex_stall", 32'(ex_stall), 32'd0);
    check("rst_illegal", 32'(illegal_branch), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // BEQ taken, predicted not taken
    issue(3'b000, 32'h55, 32'h55, 1'b0, 32'h100, 32'h200);
    // BLT not-less (neg=1, ovf=1), predicted taken, fall-through wraps
    issue(3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 32'h1234);
    // correctly predicted BLTU / BGEU
    issue(3'b110, 32'd1, 32'd2, 1'b1, 32'h300, 32'h400);
    check("bltu_no_stall", 32'(ex_stall), 32'd0);
    issue(3'b111, 32'd5, 32'd3, 1'b1, 32'h500, 32'h600);
    check("bgeu_no_stall", 32'(ex_stall), 32'd0);
    // ready held low for 3 cycles
    ready_mode = 2;
    issue(3'b001, 32'd7, 32'd9, 1'b0, 32'h700, 32'h800);
    repeat (3) @(posedge clk);
    ready_mode = 1;
    #1;
    // illegal funct3
    issue(3'b010, 32'd1, 32'd1, 1'b1, 32'h900, 32'hA00);
    issue(3'b011, 32'd4, 32'd1, 1'b0, 32'h904, 32'hA04);
    // reset while draining
    issue(3'b000, 32'd3, 32'd3, 1'b0, 32'hB00, 32'hC00);
    @(posedge clk);
    #1;
    check("drain_state", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_drain_valid", 32'(redirect_valid), 32'd0);
    check("rst_drain_flush", 32'(flush), 32'd0);
    check("rst_drain_stall", 32'(ex_stall), 32'd0);
    check("rst_drain_pc", redirect_pc, 32'd0);
    exp_q.delete();
    lat_q.delete();
    ill_q.delete();
    mdl_branches = 0;
    mdl_mispredicts = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(3'b101, 32'hFFFF_FFF0, 32'd2, 1'b1, 32'hD00, 32'hE00);

    // random traffic
    ready_mode = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ex_valid     = 1'($urandom);
        ex_is_branch = 1'b0;
        ex_funct3    = 3'($urandom);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
      end else begin
        a = $urandom;
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = $urandom;
          2:       b = a ^ 32'h8000_0000;
          default: b = a + 32'd1;
        endcase
        pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        issue(3'($urandom), a, b, 1'($urandom), pc, $urandom & 32'hFFFF_FFFC);
      end
    end

    ready_mode = 1;
    guard = 0;
    while (ex_stall && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 32'(ex_stall), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("lat_q_empty", 32'(lat_q.size()), 32'd0);
    check("ill_q_empty", 32'(ill_q.size()), 32'd0);
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches, mdl_branches);
    check("stat_mispredicts", stat_mispredicts, mdl_mispredicts);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
